// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Fetches over a req/ready
// handshake, absorbs hazard stalls through a one-entry hold buffer and applies redirects.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    output logic              if_id_valid,
    output logic [31:0]       if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [5:0]        id_opcode
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LOW_MASK = ~ADDR_W'(3);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] saved_tgt_reg, saved_tgt_next;
    logic [31:0]       hold_inst_reg, hold_inst_next;
    logic [ADDR_W-1:0] hold_pc4_reg, hold_pc4_next;
    logic              valid_reg, valid_next;
    logic [31:0]       inst_reg, inst_next;
    logic [ADDR_W-1:0] pc4_reg, pc4_next;

    logic              xfer;
    logic              redir;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] redir_tgt;
    logic              deliver;
    logic [31:0]       deliver_inst;
    logic [ADDR_W-1:0] deliver_pc4;

    // Request and address come from registered state only, never from imem_ready.
    assign imem_req  = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign imem_addr = pc_reg;
    assign xfer      = imem_req & imem_ready;

    assign redir      = branch_taken | (jump & valid_reg & ~stall);
    assign pc_plus4   = pc_reg + PC_STEP;
    assign branch_tgt = branch_target & LOW_MASK;

    generate
        if (ADDR_W > 28) begin : g_jt_wide
            assign jump_tgt = {pc4_reg[ADDR_W-1:28], inst_reg[25:0], 2'b00};
        end else begin : g_jt_narrow
            assign jump_tgt = {inst_reg[25:0], 2'b00};
        end
    endgenerate

    assign redir_tgt = branch_taken ? branch_tgt : jump_tgt;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        saved_tgt_next = saved_tgt_reg;
        hold_inst_next = hold_inst_reg;
        hold_pc4_next  = hold_pc4_reg;
        deliver        = 1'b0;
        deliver_inst   = '0;
        deliver_pc4    = '0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
                if (redir) begin
                    pc_next = redir_tgt;
                end
            end
            ST_FETCH: begin
                if (xfer) begin
                    if (redir) begin
                        pc_next = redir_tgt;
                    end else begin
                        pc_next = pc_plus4;
                        if (stall) begin
                            hold_inst_next = imem_rdata;
                            hold_pc4_next  = pc_plus4;
                            state_next     = ST_HOLD;
                        end else begin
                            deliver      = 1'b1;
                            deliver_inst = imem_rdata;
                            deliver_pc4  = pc_plus4;
                        end
                    end
                end else if (redir) begin
                    // Request must stay on the old address until memory answers.
                    saved_tgt_next = redir_tgt;
                    state_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    pc_next    = redir ? redir_tgt : saved_tgt_reg;
                    state_next = ST_FETCH;
                end else if (redir) begin
                    saved_tgt_next = redir_tgt;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    pc_next    = redir_tgt;
                    state_next = ST_FETCH;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_inst_reg;
                    deliver_pc4  = hold_pc4_reg;
                    state_next   = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_next = valid_reg;
        inst_next  = inst_reg;
        pc4_next   = pc4_reg;
        if (redir) begin
            valid_next = 1'b0;
            inst_next  = '0;
        end else if (stall) begin
            valid_next = valid_reg;
        end else if (deliver) begin
            valid_next = 1'b1;
            inst_next  = deliver_inst;
            pc4_next   = deliver_pc4;
        end else begin
            valid_next = 1'b0;
            inst_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            saved_tgt_reg <= '0;
            hold_inst_reg <= '0;
            hold_pc4_reg  <= '0;
            valid_reg     <= 1'b0;
            inst_reg      <= '0;
            pc4_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            saved_tgt_reg <= saved_tgt_next;
            hold_inst_reg <= hold_inst_next;
            hold_pc4_reg  <= hold_pc4_next;
            valid_reg     <= valid_next;
            inst_reg      <= inst_next;
            pc4_reg       <= pc4_next;
        end
    end

    assign if_id_valid = valid_reg;
    assign if_id_inst  = inst_reg;
    assign if_id_pc4   = pc4_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_opcode
            assign id_opcode[gi] = inst_reg[26+gi];
        end
    endgenerate

endmodule
